// File: rtl/mod_inv_scheduler.sv
// Round-robin scheduler that shares one modular-inverse engine between NREQ
// requesters, screens bad operands, and aborts and resets a hung engine.
module mod_inv_scheduler #(
    parameter int unsigned DW      = 256,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*DW-1:0]            req_a,
    input  logic [NREQ*DW-1:0]            req_p,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [DW-1:0]                 rsp_data,
    output logic [1:0]                    rsp_err,
    output logic [DW-1:0]                 eng_a,
    output logic [DW-1:0]                 eng_p,
    output logic                          eng_valid_in,
    input  logic [DW-1:0]                 eng_r,
    input  logic                          eng_valid_out,
    output logic                          eng_rst_n
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BAD     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FLUSH,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic            accept;
    logic [CW-1:0]   cnt;
    logic            flush_cnt;
    logic            hold_bad;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_p;

    // Requester index at offset k past the base, wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base,
                                              input int unsigned k);
        return IDW'((32'(base) + 32'd1 + k) % NREQ);
    endfunction

    // Operands the engine cannot invert: even or trivial modulus, zero a.
    function automatic logic operand_bad(input logic [DW-1:0] a,
                                         input logic [DW-1:0] p);
        return (!p[0]) || (a == '0) || (p < DW'(2));
    endfunction

    // Round-robin search; iterating from the far end lets the nearest hit win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(last_grant, $unsigned(k))]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx(last_grant, $unsigned(k));
            end
        end
    end

    // Ready is offered only to the granted requester while idle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = (state == IDLE) && grant_found;
    assign sel_a    = req_a[32'(grant_idx) * DW +: DW];
    assign sel_p    = req_p[32'(grant_idx) * DW +: DW];
    assign hold_bad = operand_bad(eng_a, eng_p);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = hold_bad ? RESP : WAIT;
            end
            WAIT: begin
                if (eng_valid_out) begin
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Job holding registers, engine controls, timeout counter and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= IDW'(NREQ - 1);
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= ERR_OK;
            eng_a        <= '0;
            eng_p        <= '0;
            eng_valid_in <= 1'b0;
            eng_rst_n    <= 1'b0;
            cnt          <= '0;
            flush_cnt    <= 1'b0;
        end else begin
            eng_valid_in <= 1'b0;
            eng_rst_n    <= (state_next != FLUSH);
            rsp_valid    <= (state_next == RESP);
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_a        <= sel_a;
                        eng_p        <= sel_p;
                        rsp_id       <= grant_idx;
                        last_grant   <= grant_idx;
                        eng_valid_in <= !operand_bad(sel_a, sel_p);
                    end
                end
                LAUNCH: begin
                    cnt <= '0;
                    if (hold_bad) begin
                        rsp_err  <= ERR_BAD;
                        rsp_data <= '0;
                    end
                end
                WAIT: begin
                    cnt       <= cnt + CW'(1);
                    flush_cnt <= 1'b0;
                    if (eng_valid_out) begin
                        rsp_data <= eng_r;
                        rsp_err  <= ERR_OK;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= ERR_TIMEOUT;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_inv_scheduler.sv
// Scoreboard bench for mod_inv_scheduler with a behavioural engine model.
module tb_mod_inv_scheduler;

    localparam int unsigned DW      = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic [1:0] err;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_p;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [DW-1:0]        rsp_data;
    logic [1:0]           rsp_err;
    logic [DW-1:0]        eng_a;
    logic [DW-1:0]        eng_p;
    logic                 eng_valid_in;
    logic [DW-1:0]        eng_r;
    logic                 eng_valid_out;
    logic                 eng_rst_n;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   last_lat = 0;
    int   n_launch = 0;
    int   n_rsp   = 0;
    int   rst_run = 0;
    int   last_run = 0;
    logic rsp_valid_q = 1'b0;

    // Engine model controls.
    logic       stub_mode = 1'b0;
    logic       stray     = 1'b0;
    int         eng_lat   = 3;
    logic       eng_busy  = 1'b0;
    int         eng_cnt   = 0;
    logic [7:0] eng_res   = '0;

    mod_inv_scheduler #(.DW(DW), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_p(req_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_a(eng_a), .eng_p(eng_p), .eng_valid_in(eng_valid_in),
        .eng_r(eng_r), .eng_valid_out(eng_valid_out), .eng_rst_n(eng_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] modinv(input logic [7:0] a, input logic [7:0] p);
        for (int x = 1; x < int'(p); x++) begin
            if (((int'(a) * x) % int'(p)) == 1) return 8'(x);
        end
        return 8'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] data, input logic [1:0] err);
        exp_t e;
        e.id = 2'(id); e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_eng_valid_in"}, 32'(eng_valid_in), 32'd0);
        check({tag, "_eng_a"}, 32'(eng_a), 32'd0);
        check({tag, "_eng_p"}, 32'(eng_p), 32'd0);
        check({tag, "_eng_rst_n"}, 32'(eng_rst_n), 32'd0);
    endtask

    // Raise one request and hold it until granted.
    task automatic do_req(input int id, input logic [7:0] a, input logic [7:0] p);
        logic got;
        got = 1'b0;
        req_a[id*8 +: 8] = a;
        req_p[id*8 +: 8] = p;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    // Wait until every expected response has been consumed.
    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 32'(done), 32'd1);
    endtask

    // Engine model: fixed latency after each start pulse, cleared by eng_rst_n.
    initial begin
        eng_valid_out = 1'b0;
        eng_r = '0;
        forever begin
            @(posedge clk); #1;
            eng_valid_out = 1'b0;
            if (!eng_rst_n) begin
                eng_busy = 1'b0;
            end else begin
                if (eng_busy) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_valid_out = 1'b1;
                        eng_r = eng_res;
                        eng_busy = 1'b0;
                    end
                end
                if (eng_valid_in && !stub_mode) begin
                    eng_busy = 1'b1;
                    eng_cnt  = eng_lat;
                    eng_res  = modinv(eng_a, eng_p);
                end
            end
            if (stray) begin
                eng_valid_out = 1'b1;
                eng_r = 8'hAA;
            end
        end
    end

    // Monitor: latency, launch count, engine-reset run length, scoreboard pops.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (|(req_valid & req_ready)) acc_cyc = cyc;
                if (rsp_valid && !rsp_valid_q) last_lat = cyc - acc_cyc;
                if (eng_valid_in) n_launch++;
                if (!eng_rst_n) begin
                    rst_run++;
                end else if (rst_run != 0) begin
                    last_run = rst_run;
                    rst_run = 0;
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_id", 32'(rsp_id), 32'(e.id));
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        n_rsp++;
                    end
                end
            end
            rsp_valid_q = rsp_valid;
        end
    end

    initial begin
        int base_launch;
        int base_rsp;
        logic ok;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_p = '0;
        rsp_ready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_eng_rst_n_rel", 32'(eng_rst_n), 32'd1);

        // Single job, requester 2: 3^-1 mod 7 = 5, latency = engine + 2.
        base_launch = n_launch;
        push_exp(2, 8'd5, 2'b00);
        do_req(2, 8'd3, 8'd7);
        wait_idle();
        check("single_launch", 32'(n_launch - base_launch), 32'd1);
        check("single_lat", 32'(last_lat), 32'(eng_lat + 2));

        // Bad operands: zero a, p<2, even p; no engine start, 2-cycle latency.
        base_launch = n_launch;
        push_exp(0, 8'd0, 2'b01);
        do_req(0, 8'd0, 8'd7);
        wait_idle();
        push_exp(1, 8'd0, 2'b01);
        do_req(1, 8'd1, 8'd1);
        wait_idle();
        push_exp(3, 8'd0, 2'b01);
        do_req(3, 8'd5, 8'd8);
        wait_idle();
        check("bad_lat", 32'(last_lat), 32'd2);
        check("bad_launch", 32'(n_launch - base_launch), 32'd0);

        // Fairness: last grant was 3, so order is 0,1,2,3,0.
        base_launch = n_launch;
        base_rsp = n_rsp;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i + 2);
            req_p[i*8 +: 8] = 8'd11;
        end
        push_exp(0, modinv(8'd2, 8'd11), 2'b00);
        push_exp(1, modinv(8'd3, 8'd11), 2'b00);
        push_exp(2, modinv(8'd4, 8'd11), 2'b00);
        push_exp(3, modinv(8'd5, 8'd11), 2'b00);
        push_exp(0, modinv(8'd2, 8'd11), 2'b00);
        req_valid = 4'hF;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (n_rsp - base_rsp >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = '0;
        check("fair_done", 32'(ok), 32'd1);
        wait_idle();
        check("fair_launch", 32'(n_launch - base_launch), 32'd5);

        // Timeout: stub engine never answers; LAUNCH+16 WAIT+2 FLUSH+1.
        stub_mode = 1'b1;
        base_launch = n_launch;
        push_exp(1, 8'd0, 2'b10);
        do_req(1, 8'd3, 8'd7);
        wait_idle();
        check("to_lat", 32'(last_lat), 32'(TIMEOUT + 4));
        check("to_flush_len", 32'(last_run), 32'd2);
        check("to_launch", 32'(n_launch - base_launch), 32'd1);
        stub_mode = 1'b0;
        push_exp(2, 8'd2, 2'b00);
        do_req(2, 8'd4, 8'd7);
        wait_idle();

        // Backpressure: 10 held cycles, stray strobe, other requester waiting.
        rsp_ready = 1'b0;
        push_exp(3, modinv(8'd2, 8'd9), 2'b00);
        do_req(3, 8'd2, 8'd9);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_reach", 32'(ok), 32'd1);
        req_a[7:0] = 8'd3;
        req_p[7:0] = 8'd7;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            stray = (k == 3);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'd5);
            check("bp_id", 32'(rsp_id), 32'd3);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        stray = 1'b0;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(rsp_valid), 32'd0);
        check("bp_popped", 32'(sb.size()), 32'd0);

        // Reset during WAIT abandons the job.
        stub_mode = 1'b1;
        do_req(3, 8'd3, 8'd7);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_hold_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        stub_mode = 1'b0;
        #1;
        check("midrst_eng_rst_n_low", 32'(eng_rst_n), 32'd0);
        @(posedge clk); #1;
        check("midrst_eng_rst_n_rel", 32'(eng_rst_n), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_rsp", 32'(rsp_valid), 32'd0);

        // Normal job after reset recovery.
        push_exp(0, 8'd5, 2'b00);
        do_req(0, 8'd3, 8'd7);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
